// File: rtl/xpb_lut_pkg.sv
// Shared types and sizing helpers for the runtime-loadable reduction-constant LUT.
package xpb_lut_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } lut_state_e;

  // request -> out_data register depth
  localparam int LUT_STAGES = 2;

  function automatic int lut_depth(input int idx_w);
    return 1 << idx_w;
  endfunction

  function automatic int lut_sum_w(input int word_w, input int num_ch);
    return word_w + $clog2(num_ch);
  endfunction

endpackage

// File: rtl/xpb_lut_bank.sv
// Single-write, NUM_CH-read register array with registered reads; entry 0 reads as zero.
module xpb_lut_bank
  import xpb_lut_pkg::*;
#(
  parameter int WORD_W = 1024,
  parameter int IDX_W  = 5,
  parameter int NUM_CH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               we_i,
  input  logic [IDX_W-1:0]                   waddr_i,
  input  logic [WORD_W-1:0]                  wdata_i,
  input  logic                               re_i,
  input  logic [NUM_CH-1:0][IDX_W-1:0]       raddr_i,
  output logic [NUM_CH-1:0][WORD_W-1:0]      rdata_o
);

  localparam int DEPTH = lut_depth(IDX_W);

  // Entry k (1..DEPTH-1) lives at mem_q[k-1]; entry 0 has no storage.
  logic [WORD_W-1:0] mem_q [DEPTH-1];

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i != '0)) mem_q[waddr_i - IDX_W'(1)] <= wdata_i;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_rd
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rdata_o[c] <= '0;
      else if (re_i) rdata_o[c] <= (raddr_i[c] == '0) ? '0 : mem_q[raddr_i[c] - IDX_W'(1)];
    end
  end

endmodule

// File: rtl/xpb_lut_rt.sv
// Multi-channel runtime-loaded LUT: load FSM, 2-stage lookup pipeline with flush on reload.
// Optional XPB_LUT_SUM_EN adds a registered cross-channel sum output (out_sum/out_sum_valid).
module xpb_lut_rt
  import xpb_lut_pkg::*;
#(
  parameter int WORD_W = 1024,
  parameter int IDX_W  = 5,
  parameter int NUM_CH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_start,
  input  logic                       load_valid,
  input  logic [WORD_W-1:0]          load_data,
  output logic                       table_ready,
  input  logic                       lkp_valid,
  input  logic [NUM_CH*IDX_W-1:0]    lkp_idx,
  output logic                       out_valid,
  output logic [NUM_CH*WORD_W-1:0]   out_data,
  output logic                       lkp_err
`ifdef XPB_LUT_SUM_EN
  ,
  output logic [lut_sum_w(WORD_W, NUM_CH)-1:0] out_sum,
  output logic                                 out_sum_valid
`endif
);

  localparam int DEPTH  = lut_depth(IDX_W);
  localparam int STAGES = LUT_STAGES;

  lut_state_e                   state_q, state_d;
  logic [IDX_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic                         we;
  logic                         lkp_acc;
  logic [STAGES:1]              vld_q;
  logic [STAGES:0]              vld_pipe;
  logic [NUM_CH-1:0][IDX_W-1:0] idx_q;
  logic                         lkp_err_q;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    we       = 1'b0;
    if (load_start) begin
      state_d  = LOADING;
      wr_ptr_d = IDX_W'(1);
    end else begin
      case (state_q)
        LOADING: begin
          if (load_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
            if (wr_ptr_q == IDX_W'(DEPTH - 1)) state_d = READY;
          end
        end
        default: ;
      endcase
    end
  end

  // A lookup colliding with load_start is dropped without flagging an error.
  assign lkp_acc  = lkp_valid && (state_q == READY) && !load_start;
  assign vld_pipe = {vld_q, lkp_acc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      wr_ptr_q  <= '0;
      vld_q     <= '0;
      idx_q     <= '0;
      lkp_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      vld_q    <= load_start ? '0 : vld_pipe[STAGES-1:0];
      if (lkp_acc) idx_q <= lkp_idx;
      if (lkp_valid && (state_q != READY)) lkp_err_q <= 1'b1;
    end
  end

  xpb_lut_bank #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W),
    .NUM_CH (NUM_CH)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (load_data),
    .re_i    (vld_pipe[STAGES-1] && !load_start),
    .raddr_i (idx_q),
    .rdata_o (out_data)
  );

  assign table_ready = (state_q == READY);
  assign out_valid   = vld_pipe[STAGES];
  assign lkp_err     = lkp_err_q;

`ifdef XPB_LUT_SUM_EN
  localparam int SUM_W = lut_sum_w(WORD_W, NUM_CH);

  logic [NUM_CH-1:0][WORD_W-1:0] res;
  logic [SUM_W-1:0]              sum_d;

  assign res = out_data;

  always_comb begin
    sum_d = '0;
    for (int c = 0; c < NUM_CH; c++) sum_d = sum_d + SUM_W'(res[c]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum       <= '0;
      out_sum_valid <= 1'b0;
    end else begin
      out_sum_valid <= out_valid && !load_start;
      if (out_valid && !load_start) out_sum <= sum_d;
    end
  end
`endif

endmodule

// File: tb/tb_xpb_lut_rt.sv
// Randomized self-checking bench for xpb_lut_rt against a queue-based behavioural model.
module tb_xpb_lut_rt;

  localparam int WORD_W = 16;
  localparam int IDX_W  = 3;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 8;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     load_start = 1'b0;
  logic                     load_valid = 1'b0;
  logic [WORD_W-1:0]        load_data = '0;
  logic                     lkp_valid = 1'b0;
  logic [NUM_CH*IDX_W-1:0]  lkp_idx = '0;
  logic                     table_ready, out_valid, lkp_err;
  logic [NUM_CH*WORD_W-1:0] out_data;
`ifdef XPB_LUT_SUM_EN
  logic [WORD_W:0]          out_sum;
  logic                     out_sum_valid;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  xpb_lut_rt #(.WORD_W(WORD_W), .IDX_W(IDX_W), .NUM_CH(NUM_CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .table_ready (table_ready),
    .lkp_valid   (lkp_valid),
    .lkp_idx     (lkp_idx),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .lkp_err     (lkp_err)
`ifdef XPB_LUT_SUM_EN
    ,
    .out_sum       (out_sum),
    .out_sum_valid (out_sum_valid)
`endif
  );

  // Reference model: table contents, load progress and a queue of results due per cycle.
  typedef struct { int due; logic [31:0] data; } res_t;
  logic [WORD_W-1:0] m_tbl [DEPTH];
  int                m_cnt, cyc;
  bit                m_loading, m_ready, m_err, e_valid;
  logic [31:0]       e_data;
  res_t              pend[$];
`ifdef XPB_LUT_SUM_EN
  res_t              spend[$];
  bit                e_sum_valid;
  logic [16:0]       e_sum;
`endif

  task automatic model_reset();
    m_tbl[0] = '0; m_cnt = 0; m_loading = 0; m_ready = 0; m_err = 0;
    pend.delete(); e_valid = 0; e_data = '0;
`ifdef XPB_LUT_SUM_EN
    spend.delete(); e_sum_valid = 0; e_sum = '0;
`endif
  endtask

  // Applies the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit   was_ready;
    res_t r;
    if (!rst_n) begin model_reset(); return; end
    cyc++;
    was_ready = m_ready;
    if (lkp_valid && !was_ready) m_err = 1;
    if (load_start) begin
      pend.delete();
`ifdef XPB_LUT_SUM_EN
      spend.delete();
`endif
      m_loading = 1; m_ready = 0; m_cnt = 0;
    end else begin
      if (lkp_valid && was_ready) begin
        r.due  = cyc + 1;
        r.data = {m_tbl[lkp_idx[5:3]], m_tbl[lkp_idx[2:0]]};
        pend.push_back(r);
      end
      if (m_loading && load_valid) begin
        m_cnt++;
        m_tbl[m_cnt] = load_data;
        if (m_cnt == DEPTH - 1) begin m_loading = 0; m_ready = 1; end
      end
    end
    e_valid = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      e_valid = 1;
      e_data  = r.data;
`ifdef XPB_LUT_SUM_EN
      r.due  = cyc + 1;
      r.data = {16'h0, e_data[15:0]} + {16'h0, e_data[31:16]};
      spend.push_back(r);
`endif
    end
`ifdef XPB_LUT_SUM_EN
    e_sum_valid = 0;
    if (spend.size() > 0 && spend[0].due == cyc) begin
      r = spend.pop_front();
      e_sum_valid = 1;
      e_sum = r.data[16:0];
    end
`endif
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] base, input logic [15:0] inc,
                         input int first, input int last, input bit start);
    int i;
    if (start) begin
      load_start = 1; load_valid = 1'($urandom); load_data = 16'($urandom);
      tick();
      load_start = 0;
    end
    i = first;
    while (i <= last) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = load_valid ? base + inc * 16'(i) : 16'($urandom);
      tick();
      if (load_valid) i++;
      n_chk++;
      if (table_ready !== m_ready || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL load_progress: ready=%b valid=%b, expected ready=%b valid=0", table_ready, out_valid, m_ready);
      end
    end
    load_valid = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    model_reset();
    #1;
    n_chk++;
    if ({table_ready, out_valid, lkp_err} !== 3'b000 || out_data !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b valid=%b err=%b data=%h, expected all zero", table_ready, out_valid, lkp_err, out_data);
    end
`ifdef XPB_LUT_SUM_EN
    n_chk++;
    if (out_sum !== '0 || out_sum_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sum: sum=%h valid=%b, expected 0", out_sum, out_sum_valid);
    end
`endif
    tick(); tick();
    rst_n = 1;
    tick();
    n_chk++;
    if (table_ready !== 1'b0 || lkp_err !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: ready=%b err=%b valid=%b, expected 0", table_ready, lkp_err, out_valid);
    end
  endtask

  task automatic test_load_lookup();
    do_load(16'h0000, 16'h1111, 1, 7, 1);
    n_chk++;
    if (table_ready !== 1'b1) begin
      n_err++; $display("FAIL ready_after_load: got %b expected 1", table_ready);
    end
    lkp_valid = 1; lkp_idx = {3'd5, 3'd2};
    tick();
    lkp_valid = 0;
    n_chk++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: valid=%b expected 0", out_valid); end
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 32'h5555_2222) begin
      n_err++; $display("FAIL basic_lookup: valid=%b data=%h, expected 1 55552222", out_valid, out_data);
    end
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 32'h5555_2222) begin
      n_err++; $display("FAIL hold: valid=%b data=%h, expected 0 55552222", out_valid, out_data);
    end
  endtask

  task automatic test_idx0();
    lkp_valid = 1; lkp_idx = '0;
    tick();
    lkp_valid = 0;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 32'h0) begin
      n_err++; $display("FAIL idx_zero: valid=%b data=%h, expected 1 00000000", out_valid, out_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    for (int t = 0; t < 5; t++) begin
      lkp_valid = (t < 3);
      lkp_idx   = {3'(t + 1), 3'(t + 1)};
      tick();
      v = 16'h1111 * 16'(t);
      if (t >= 1 && t <= 3) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_data !== {v, v}) begin
          n_err++; $display("FAIL back_to_back[%0d]: valid=%b data=%h, expected 1 %h", t, out_valid, out_data, {v, v});
        end
      end else if (t == 4) begin
        n_chk++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL back_to_back_end: valid=%b expected 0", out_valid); end
      end
    end
  endtask

  task automatic test_collision();
    lkp_valid = 1; lkp_idx = 6'($urandom); load_start = 1;
    tick();
    lkp_valid = 0; load_start = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b0 || lkp_err !== 1'b0 || table_ready !== 1'b0) begin
        n_err++; $display("FAIL collision: valid=%b err=%b ready=%b, expected 0 0 0", out_valid, lkp_err, table_ready);
      end
    end
  endtask

  task automatic test_flush();
    do_load(16'h0000, 16'h1111, 1, 7, 1);
    lkp_valid = 1; lkp_idx = {3'd3, 3'd4};
    tick();
    lkp_valid = 0; load_start = 1;
    tick();
    load_start = 0;
    for (int t = 0; t < 2; t++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush[%0d]: valid=%b expected 0", t, out_valid); end
    end
    do_load(16'hA000, 16'h0001, 1, 7, 1);
    lkp_valid = 1; lkp_idx = {3'd7, 3'd7};
    tick();
    lkp_valid = 0;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 32'hA007_A007) begin
      n_err++; $display("FAIL reload_lookup: valid=%b data=%h, expected 1 a007a007", out_valid, out_data);
    end
  endtask

  task automatic test_partial_reload();
    do_load(16'hB000, 16'h0001, 1, 3, 1);
    do_load(16'hC000, 16'h0001, 1, 6, 1);
    n_chk++;
    if (table_ready !== 1'b0) begin n_err++; $display("FAIL partial_not_ready: got %b expected 0", table_ready); end
    do_load(16'hC000, 16'h0001, 7, 7, 0);
    n_chk++;
    if (table_ready !== 1'b1) begin n_err++; $display("FAIL partial_ready: got %b expected 1", table_ready); end
    lkp_valid = 1; lkp_idx = {3'd1, 3'd7};
    tick();
    lkp_valid = 0;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 32'hC001_C007) begin
      n_err++; $display("FAIL partial_lookup: valid=%b data=%h, expected 1 c001c007", out_valid, out_data);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 120; t++) begin
      lkp_valid  = 1'($urandom);
      lkp_idx    = 6'($urandom);
      load_start = ($urandom_range(0, 24) == 0);
      load_valid = 1'($urandom);
      load_data  = 16'($urandom);
      tick();
      n_chk++;
      if (out_valid !== e_valid || out_data !== e_data || lkp_err !== m_err || table_ready !== m_ready) begin
        n_err++;
        $display("FAIL random[%0d]: valid=%b data=%h err=%b ready=%b, expected %b %h %b %b",
                 t, out_valid, out_data, lkp_err, table_ready, e_valid, e_data, m_err, m_ready);
      end
`ifdef XPB_LUT_SUM_EN
      n_chk++;
      if (out_sum_valid !== e_sum_valid || out_sum !== e_sum) begin
        n_err++; $display("FAIL random_sum[%0d]: valid=%b sum=%h, expected %b %h", t, out_sum_valid, out_sum, e_sum_valid, e_sum);
      end
`endif
    end
    lkp_valid = 0; load_start = 0; load_valid = 0;
  endtask

`ifdef XPB_LUT_SUM_EN
  task automatic test_sum();
    do_load(16'hFFFF, 16'h0000, 1, 7, 1);
    lkp_valid = 1; lkp_idx = {3'd7, 3'd7};
    tick();
    lkp_valid = 0;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_sum_valid !== 1'b0) begin
      n_err++; $display("FAIL sum_latency: valid=%b sum_valid=%b, expected 1 0", out_valid, out_sum_valid);
    end
    tick();
    n_chk++;
    if (out_sum_valid !== 1'b1 || out_sum !== 17'h1FFFE) begin
      n_err++; $display("FAIL sum_value: valid=%b sum=%h, expected 1 1fffe", out_sum_valid, out_sum);
    end
  endtask
`endif

  task automatic test_async_reset();
    do_load(16'h0000, 16'h1111, 1, 7, 1);
    lkp_valid = 1; lkp_idx = {3'd7, 3'd1};
    tick();
    lkp_valid = 0;
    #2 rst_n = 0;
    model_reset();
    #1;
    n_chk++;
    if ({table_ready, out_valid, lkp_err} !== 3'b000 || out_data !== '0) begin
      n_err++;
      $display("FAIL async_reset: ready=%b valid=%b err=%b data=%h, expected all zero", table_ready, out_valid, lkp_err, out_data);
    end
`ifdef XPB_LUT_SUM_EN
    n_chk++;
    if (out_sum !== '0 || out_sum_valid !== 1'b0) begin
      n_err++; $display("FAIL async_reset_sum: sum=%h valid=%b, expected 0", out_sum, out_sum_valid);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1;
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || table_ready !== 1'b0) begin
      n_err++; $display("FAIL post_reset: valid=%b ready=%b, expected 0 0", out_valid, table_ready);
    end
  endtask

  task automatic test_err_before_load();
    lkp_valid = 1; lkp_idx = 6'($urandom);
    tick();
    lkp_valid = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_chk++;
      if (out_valid !== 1'b0 || lkp_err !== 1'b1) begin
        n_err++; $display("FAIL err_empty[%0d]: valid=%b err=%b, expected 0 1", t, out_valid, lkp_err);
      end
    end
    do_load(16'h0000, 16'h1111, 1, 7, 1);
    lkp_valid = 1; lkp_idx = {3'd3, 3'd4};
    tick();
    lkp_valid = 0;
    tick();
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 32'h3333_4444 || lkp_err !== 1'b1) begin
      n_err++; $display("FAIL err_sticky: valid=%b data=%h err=%b, expected 1 33334444 1", out_valid, out_data, lkp_err);
    end
  endtask

  initial begin
    cyc = 0;
    model_reset();
    test_reset();
    test_load_lookup();
    test_idx0();
    test_back_to_back();
    test_collision();
    test_flush();
    test_partial_reload();
    test_random();
`ifdef XPB_LUT_SUM_EN
    test_sum();
`endif
    test_async_reset();
    test_err_before_load();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
